timer_gen_prog: RTL and testbench

TIMER_GEN_PROG -- requirements
Module: timer_gen_prog

---
 rtl/timer_pkg.sv | 28 ++
 rtl/timer_gen_prog_if.sv | 27 ++
 rtl/timer_ch.sv | 105 ++++++++++
 rtl/timer_gen_prog.sv | 57 +++++
 tb/tb_timer_gen_prog.sv | 126 ++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the programmable timer generator: mode encodings,
// channel sequencing states and the default prescale constant.
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_PERIODIC = 2'b00,
    MODE_CLOCK    = 2'b01,
    MODE_ONESHOT  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_RUN,
    CH_SHOT
  } ch_state_e;

  localparam int unsigned PRESCALE_DEFAULT = 50;

  // Encoding 2'b11 has no mode of its own and behaves as periodic.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_CLOCK;
      2'b10:   return MODE_ONESHOT;
      default: return MODE_PERIODIC;
    endcase
  endfunction

endpackage

// File: rtl/timer_gen_prog_if.sv
// Channel control/status bundle of the timer generator; the master drives
// configuration and start pulses, the slave (timer) returns the timing outputs.
interface timer_gen_prog_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
);

  logic [NUM_CH-1:0]       ch_en;
  logic [2*NUM_CH-1:0]     ch_mode;
  logic [CNT_W*NUM_CH-1:0] ch_period;
  logic [NUM_CH-1:0]       ch_start;
  logic                    t_base;
  logic [NUM_CH-1:0]       ch_tick;
  logic [NUM_CH-1:0]       ch_clk;
  logic [NUM_CH-1:0]       ch_busy;

  modport master (
    output ch_en, ch_mode, ch_period, ch_start,
    input  t_base, ch_tick, ch_clk, ch_busy
  );

  modport slave (
    input  ch_en, ch_mode, ch_period, ch_start,
    output t_base, ch_tick, ch_clk, ch_busy
  );

endinterface

// File: rtl/timer_ch.sv
// One timer channel: counts shared base ticks against a latched period and
// produces periodic ticks, a 50% clock, or a single one-shot tick.
module timer_ch
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             base_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             start_i,
  output logic             tick_o,
  output logic             clk_o,
  output logic             busy_o
);

  ch_state_e        state_q, state_d;
  mode_e            mode_q, mode_d, mode_in;
  logic [CNT_W-1:0] per_q, per_d, per_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, clk_q, clk_d, tick_q, tick_d;
  logic             load, running, bnd;

  // base_i is the cycle before t_base, so registered ticks line up with it.
  always_comb begin
    mode_in = decode_mode(mode_i);
    per_in  = (period_i == '0) ? CNT_W'(1) : period_i;
    load    = en_i && (start_i || !en_q);
    running = (state_q == CH_RUN) || (state_q == CH_SHOT);
    bnd     = running && base_i && (cnt_q == per_q - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= CH_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = CH_IDLE;
    end else if (load) begin
      if (mode_in != MODE_ONESHOT) state_d = CH_RUN;
      else if (start_i)            state_d = CH_SHOT;
      else                         state_d = CH_IDLE;
    end else if (bnd) begin
      if (state_q == CH_SHOT || mode_in == MODE_ONESHOT) state_d = CH_IDLE;
      else                                               state_d = CH_RUN;
    end
  end

  always_comb begin
    tick_o = tick_q;
    clk_o  = clk_q;
    busy_o = (state_q == CH_SHOT);
  end

  // A start or enable rise takes priority over a coincident boundary.
  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    mode_d = mode_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (load) begin
      cnt_d  = '0;
      per_d  = per_in;
      mode_d = mode_in;
      if (mode_in != MODE_CLOCK) clk_d = 1'b0;
    end else if (bnd) begin
      cnt_d  = '0;
      per_d  = per_in;
      mode_d = mode_in;
      tick_d = 1'b1;
      clk_d  = (mode_q == MODE_CLOCK && mode_in == MODE_CLOCK) ? ~clk_q : 1'b0;
    end else if (running && base_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= 1'b0;
      cnt_q  <= '0;
      per_q  <= '0;
      mode_q <= MODE_PERIODIC;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      en_q   <= en_i;
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      mode_q <= mode_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/timer_gen_prog.sv
// Programmable multi-channel timer: a shared free-running prescaler feeding
// NUM_CH independent timer_ch channels.
module timer_gen_prog
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  timer_gen_prog_if.slave  bus
);

  localparam int unsigned     PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]   ps_cnt_q, ps_cnt_d;
  logic              ps_last, t_base_q;
  logic [NUM_CH-1:0] tick_w, clk_w, busy_w;

  always_comb begin
    ps_last  = (ps_cnt_q == PS_LAST);
    ps_cnt_d = ps_last ? '0 : ps_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt_q <= '0;
      t_base_q <= 1'b0;
    end else begin
      ps_cnt_q <= ps_cnt_d;
      t_base_q <= ps_last;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .base_i   (ps_last),
      .en_i     (bus.ch_en[g]),
      .mode_i   (bus.ch_mode[2*g +: 2]),
      .period_i (bus.ch_period[CNT_W*g +: CNT_W]),
      .start_i  (bus.ch_start[g]),
      .tick_o   (tick_w[g]),
      .clk_o    (clk_w[g]),
      .busy_o   (busy_w[g])
    );
  end

  assign bus.t_base  = t_base_q;
  assign bus.ch_tick = tick_w;
  assign bus.ch_clk  = clk_w;
  assign bus.ch_busy = busy_w;

endmodule

// File: tb/tb_timer_gen_prog.sv
// Directed bench for timer_gen_prog: four channels exercised together against
// hand-computed event cycles, then a reset during an active one-shot.
module tb_timer_gen_prog;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned PRESCALE = 50;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc   = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  timer_gen_prog_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  timer_gen_prog #(.PRESCALE(PRESCALE), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic exp_tbase(input int unsigned c);
    return (c != 0) && (c % 50 == 0);
  endfunction

  // Hand-derived event cycles for the stimulus schedule in the main loop.
  function automatic logic [3:0] exp_tick(input int unsigned c);
    logic [3:0] t;
    t[0] = c inside {150, 300, 450, 600, 750, 900, 1100};
    t[1] = c inside {100, 200, 300, 500, 700, 1000};
    t[2] = c inside {250, 650};
    t[3] = (c >= 750) && (c % 50 == 0) && (c != 850);
    return t;
  endfunction

  function automatic logic [3:0] exp_clk(input int unsigned c);
    logic [3:0] k;
    k    = 4'b0000;
    k[1] = (c >= 100 && c < 200) || (c >= 300 && c < 500) || (c >= 700 && c < 1000);
    return k;
  endfunction

  function automatic logic [3:0] exp_busy(input int unsigned c);
    logic [3:0] b;
    b    = 4'b0000;
    b[2] = (c >= 10 && c < 250) || (c >= 260 && c < 650) || (c >= 1010);
    return b;
  endfunction

  initial begin
    bus.ch_en     = 4'b0111;
    bus.ch_start  = 4'b0000;
    bus.ch_mode   = {2'b00, 2'b10, 2'b01, 2'b00};
    bus.ch_period = {16'd0, 16'd5, 16'd2, 16'd3};

    repeat (3) @(posedge clk);
    #1;
    check("rst_t_base",  bus.t_base,  32'd0);
    check("rst_ch_tick", bus.ch_tick, 32'd0);
    check("rst_ch_clk",  bus.ch_clk,  32'd0);
    check("rst_ch_busy", bus.ch_busy, 32'd0);

    reset = 1'b0;
    cyc   = 0;
    for (int unsigned i = 1; i <= 1120; i++) begin
      step();
      check("t_base",  bus.t_base,  exp_tbase(cyc));
      check("ch_tick", bus.ch_tick, exp_tick(cyc));
      check("ch_clk",  bus.ch_clk,  exp_clk(cyc));
      check("ch_busy", bus.ch_busy, exp_busy(cyc));
      case (cyc)
        9, 259, 399, 1009: bus.ch_start = 4'b0100;
        819:               bus.ch_start = 4'b0010;
        849:               bus.ch_start = 4'b1000;
        10, 260, 400, 820, 850, 1010: bus.ch_start = 4'b0000;
        249:               bus.ch_period[31:16] = 16'd4;
        700:               bus.ch_en[3] = 1'b1;
        949:               bus.ch_en[0] = 1'b0;
        959:               bus.ch_en[0] = 1'b1;
        default: ;
      endcase
    end

    // Abort the ch2 one-shot that started at cycle 1010.
    reset      = 1'b1;
    bus.ch_en  = 4'b0100;
    @(posedge clk);
    #1;
    check("abort_busy",   bus.ch_busy, 32'd0);
    check("abort_tick",   bus.ch_tick, 32'd0);
    check("abort_t_base", bus.t_base,  32'd0);
    check("abort_clk",    bus.ch_clk,  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    for (int unsigned i = 1; i <= 160; i++) begin
      step();
      check("post_t_base",  bus.t_base,  exp_tbase(cyc));
      check("post_ch_tick", bus.ch_tick, 32'd0);
      check("post_ch_clk",  bus.ch_clk,  32'd0);
      check("post_ch_busy", bus.ch_busy, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
